hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle control-unit interface; sits beside the decode stage of the pipelined datapath.
- Tracks in-flight register writes in a DEPTH-entry shift scoreboard.
- Generates load-use stall, branch flush and per-operand forwarding selects.
- Runs a halt-drain state machine so `halt` is raised only after the pipeline empties.

Parameters:
- DEPTH, 3, post-decode stages holding a pending write; index 0 = EX, 1 = MEM, 2 = WB; legal range 1..7.
- REGW, 5, register-select width; matches regbits_t.
- FWDW, $clog2(DEPTH+1), width of each forward select.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- nRST  input  1  asynchronous active-low reset.
- advance  input  1  pipeline-wide enable; deasserted on an imem/dmem miss.
- id_valid  input  1  decode holds a real instruction.
- id_rs  input  REGW  source A select.
- id_rt  input  REGW  source B select.
- id_use_rs  input  1  instruction reads rs.
- id_use_rt  input  1  instruction reads rt.
- id_wen  input  1  instruction writes a register (RegWEN).
- id_wsel  input  REGW  destination select (post-RegDest mux).
- id_load  input  1  instruction is a load (dmemREN).
- id_halt  input  1  decode holds HALT.
- ex_branch_taken  input  1  branch/jump resolved taken in EX.
- stall  output  1  hold PC and IF/ID; insert a bubble into EX.
- flush  output  1  squash IF/ID.
- fwd_a  output  FWDW  0 = regfile, k = result of stage k-1.
- fwd_b  output  FWDW  as fwd_a, for rt.
- halt  output  1  sticky; pipeline drained after HALT.
- busy  output  1  at least one scoreboard entry valid.

Behaviour:
- Reset (async, nRST=0): all entries invalid, FSM=RUN; stall, flush, fwd_a, fwd_b, halt, busy all 0.
- Entry fields: {v, wsel, load}. `match(s, r)` = v[s] and wsel[s]==r and r!=0 and use-bit set. Register 0 never matches.
- Outputs are combinational from inputs plus state (zero latency). All state changes only when advance=1; when advance=0 the scoreboard and FSM hold.
- Load-use: stall=1 if match(0, rs or rt) and load[0].
- Forwarding: fwd_a = lowest s satisfying match(s, rs) (nearest producer wins), encoded as s+1; 0 if none. fwd_b is the same for rt.
- Flush: flush = ex_branch_taken. Flush has priority: when flush=1, stall=0 and the decode instruction is not inserted.
- Shift on an advancing edge: entry[k] <= entry[k-1] for k ≥ 1; entry[DEPTH-1] retires.
- Entry 0 on an advancing edge:
  - stall, flush, or DRAIN: bubble.
  - otherwise: {id_valid & id_wen & id_wsel!=0, id_wsel, id_load}.
- busy = OR of all v.
- FSM RUN→DRAIN: id_valid & id_halt & ~flush & ~stall & advance. A HALT with flush=1 is discarded.
- FSM DRAIN: stall forced 1; fwd still valid. Go to HALTED on the first advancing edge where busy=0.
- FSM HALTED: halt=1; stall forced 1; no exit except reset.
- Reset mid-drain returns the FSM to RUN and clears the scoreboard.

Optional Feature:
- HAZARD_FWD_EN defined: forwarding as above.
- Undefined: fwd_a and fwd_b are tied to 0, and stall=1 whenever match(s, rs or rt) holds for any s (full RAW interlock).
- Both builds: load-use stall, flush and halt behaviour are unchanged.

Decomposition:
- cpu_types_pkg gains sb_entry_t (packed v, wsel, load) and hz_state_t enum {RUN, DRAIN, HALTED}; regbits_t is reused.
- hazard_scoreboard_if carries the ports, with modports hz and tb.
- One sub-module, sb_match: a combinational priority finder returning the lowest matching stage index plus a hit flag. It is instantiated twice, once for rs and once for rt.

Test Plan:
- Raw forward: `add $3` then next cycle `sub` reading $3 via rs (advance=1) → fwd_a=1, stall=0. One cycle later, a reader of $3 sees fwd_a=2.
- Load-use: `lw $4` followed by `add` using $4 as rt → stall=1 for exactly one cycle, entry0 bubble, then fwd_b=2. Without HAZARD_FWD_EN: stall for 3 cycles, fwd_b=0.
- Register zero: writer and reader of $0 back-to-back → fwd_a=0, fwd_b=0, stall=0.
- Flush priority: ex_branch_taken=1 while decode holds a load-use consumer plus id_halt → flush=1, stall=0, FSM stays RUN, next entry0 invalid.
- Halt drain, DEPTH=3: HALT accepted behind two writers → halt rises after the 3rd advancing edge. Holding advance=0 for 2 cycles mid-drain delays halt by exactly 2 cycles.
- Reset in DRAIN: nRST low asynchronously mid-cycle → stall=0, busy=0, halt=0 immediately; the FSM is in RUN after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register selects, scoreboard entries and the
// halt-drain state encoding used by the hazard scoreboard.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  // One pending register write travelling down the pipeline.
  typedef struct packed {
    logic     v;
    regbits_t wsel;
    logic     load;
  } sb_entry_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard interface: decode/EX status in, stall/flush/forward
// selects and halt/busy status out. Modport hz faces the scoreboard,
// modport tb faces whoever drives the decode stage.
interface hazard_scoreboard_if #(
  parameter int DEPTH = 3,
  parameter int REGW  = 5,
  parameter int FWDW  = $clog2(DEPTH + 1)
);

  logic            advance;
  logic            id_valid;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic            id_wen;
  logic [REGW-1:0] id_wsel;
  logic            id_load;
  logic            id_halt;
  logic            ex_branch_taken;
  logic            stall;
  logic            flush;
  logic [FWDW-1:0] fwd_a;
  logic [FWDW-1:0] fwd_b;
  logic            halt;
  logic            busy;

  modport hz (
    input  advance, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wen, id_wsel, id_load, id_halt, ex_branch_taken,
    output stall, flush, fwd_a, fwd_b, halt, busy
  );

  modport tb (
    output advance, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wen, id_wsel, id_load, id_halt, ex_branch_taken,
    input  stall, flush, fwd_a, fwd_b, halt, busy
  );

endinterface

// File: rtl/sb_match.sv
// Combinational priority finder: returns the lowest scoreboard stage whose
// pending write targets register r, plus a hit flag. Register 0 and an
// operand that is not read never match.
module sb_match #(
  parameter int DEPTH = 3,
  parameter int REGW  = 5,
  parameter int IDXW  = 2
) (
  input  logic [DEPTH-1:0]           v,
  input  logic [DEPTH-1:0][REGW-1:0] wsel,
  input  logic [REGW-1:0]            r,
  input  logic                       use_r,
  output logic [IDXW-1:0]            idx,
  output logic                       hit
);

  logic [DEPTH-1:0] hits;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign hits[gi] = v[gi] & use_r & (r != '0) & (wsel[gi] == r);
    end
  endgenerate

  // Scan from the oldest stage down so the nearest producer wins.
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (hits[s]) begin
        idx = IDXW'(s);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard beside the decode stage: tracks in-flight register
// writes in a DEPTH-entry shift scoreboard (0 = EX), produces load-use
// stall, branch flush and operand forward selects, and drains the pipeline
// before raising a sticky halt.
// Build option HAZARD_FWD_EN: when defined, operands are forwarded from the
// nearest producer; when undefined, forward selects stay 0 and any pending
// write to a source register interlocks decode until it retires.
module hazard_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 3,
  // Entries are stored as sb_entry_t, so REGW tracks the regbits_t width.
  parameter int REGW  = $bits(regbits_t),
  parameter int FWDW  = $clog2(DEPTH + 1)
) (
  input logic             CLK,
  input logic             nRST,
  hazard_scoreboard_if.hz bus
);

  sb_entry_t [DEPTH-1:0]           sb;
  hz_state_t                       state;
  logic                            halt_reg;

  logic [DEPTH-1:0]                v_vec;
  logic [DEPTH-1:0][REGW-1:0]      wsel_vec;
  logic [FWDW-1:0]                 rs_idx;
  logic [FWDW-1:0]                 rt_idx;
  logic                            rs_hit;
  logic                            rt_hit;
  logic                            load_use;
  logic                            raw_stall;
  logic                            flush_int;
  logic                            stall_int;
  logic                            bubble;
  logic                            halt_accept;
  logic                            busy_int;
  sb_entry_t                       entry_new;
  logic                            unused_last_load;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_unpack
      assign v_vec[gi]    = sb[gi].v;
      assign wsel_vec[gi] = sb[gi].wsel;
    end
  endgenerate

  // The load flag only matters in EX; the oldest copy has no consumer.
  assign unused_last_load = sb[DEPTH-1].load;

  sb_match #(.DEPTH(DEPTH), .REGW(REGW), .IDXW(FWDW)) u_match_rs (
    .v     (v_vec),
    .wsel  (wsel_vec),
    .r     (bus.id_rs),
    .use_r (bus.id_use_rs),
    .idx   (rs_idx),
    .hit   (rs_hit)
  );

  sb_match #(.DEPTH(DEPTH), .REGW(REGW), .IDXW(FWDW)) u_match_rt (
    .v     (v_vec),
    .wsel  (wsel_vec),
    .r     (bus.id_rt),
    .use_r (bus.id_use_rt),
    .idx   (rt_idx),
    .hit   (rt_hit)
  );

  assign busy_int = |v_vec;

  // A load in EX cannot be forwarded to the instruction right behind it.
  assign load_use = sb[0].v & sb[0].load &
                    ((rs_hit & (rs_idx == '0)) | (rt_hit & (rt_idx == '0)));

`ifdef HAZARD_FWD_EN
  assign raw_stall = 1'b0;
  assign bus.fwd_a = rs_hit ? rs_idx + FWDW'(1) : '0;
  assign bus.fwd_b = rt_hit ? rt_idx + FWDW'(1) : '0;
`else
  assign raw_stall = rs_hit | rt_hit;
  assign bus.fwd_a = '0;
  assign bus.fwd_b = '0;
`endif

  // A taken branch squashes decode, so a hazard on that instruction is moot;
  // draining or halted always holds the front end.
  assign flush_int   = bus.ex_branch_taken;
  assign stall_int   = (state != RUN) | ((load_use | raw_stall) & ~flush_int);
  assign bubble      = stall_int | flush_int | (state == DRAIN);
  assign halt_accept = bus.id_valid & bus.id_halt & ~flush_int & ~stall_int;
  assign entry_new   = {bus.id_valid & bus.id_wen & (bus.id_wsel != '0),
                        bus.id_wsel, bus.id_load};

  assign bus.stall = stall_int;
  assign bus.flush = flush_int;
  assign bus.busy  = busy_int;
  assign bus.halt  = halt_reg;

  // Shift the scoreboard one stage per advancing edge; EX takes decode or a bubble.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sb <= '0;
    end else if (bus.advance) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        sb[k] <= sb[k-1];
      end
      sb[0] <= bubble ? '0 : entry_new;
    end
  end

  // Halt-drain FSM: accept HALT, wait for the scoreboard to empty, then halt forever.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= RUN;
      halt_reg <= 1'b0;
    end else if (bus.advance) begin
      case (state)
        RUN: begin
          if (halt_accept) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!busy_int) begin
            state    <= HALTED;
            halt_reg <= 1'b1;
          end
        end
        default: begin
          state    <= HALTED;
          halt_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a per-cycle reference model of
// pending writes and the run/drain/halted mode.
module tb_hazard_scoreboard;

  localparam int DEPTH = 3;
  localparam int REGW  = 5;

  logic CLK = 1'b0;
  logic nRST;
  int   total = 0;
  int   bad   = 0;

  hazard_scoreboard_if #(.DEPTH(DEPTH), .REGW(REGW)) bus ();

  hazard_scoreboard #(.DEPTH(DEPTH), .REGW(REGW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.hz)
  );

  always #5 CLK = ~CLK;

  // Reference model: pending writes by stage (0 = EX) and a mode number
  // (0 = running, 1 = draining, 2 = halted).
  int m_v [DEPTH];
  int m_w [DEPTH];
  int m_l [DEPTH];
  int m_mode = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nearest(input int r, input bit use_r);
    for (int s = 0; s < DEPTH; s++) begin
      if (use_r && r != 0 && m_v[s] != 0 && m_w[s] == r) return s;
    end
    return -1;
  endfunction

  function automatic void model_eval(output int e_stall, output int e_flush,
                                     output int e_fa, output int e_fb,
                                     output int e_busy, output int e_halt);
    int na;
    int nb;
    bit lu;
    bit raw;
    na = nearest(int'(bus.id_rs), bus.id_use_rs);
    nb = nearest(int'(bus.id_rt), bus.id_use_rt);
    lu = (m_v[0] != 0) && (m_l[0] != 0) && (na == 0 || nb == 0);
`ifdef HAZARD_FWD_EN
    raw  = 1'b0;
    e_fa = na + 1;
    e_fb = nb + 1;
`else
    raw  = (na >= 0) || (nb >= 0);
    e_fa = 0;
    e_fb = 0;
`endif
    e_flush = bus.ex_branch_taken ? 1 : 0;
    e_stall = (m_mode != 0 || (e_flush == 0 && (lu || raw))) ? 1 : 0;
    e_busy  = 0;
    for (int s = 0; s < DEPTH; s++) if (m_v[s] != 0) e_busy = 1;
    e_halt  = (m_mode == 2) ? 1 : 0;
  endfunction

  // Model state update on each advancing edge.
  always @(posedge CLK or negedge nRST) begin
    int es, ef, ea, eb, ebusy, eh;
    bit accept;
    if (nRST !== 1'b1) begin
      for (int s = 0; s < DEPTH; s++) begin
        m_v[s] <= 0;
        m_w[s] <= 0;
        m_l[s] <= 0;
      end
      m_mode <= 0;
    end else if (bus.advance === 1'b1) begin
      model_eval(es, ef, ea, eb, ebusy, eh);
      accept = (m_mode == 0) && bus.id_valid && bus.id_halt && ef == 0 && es == 0;
      for (int s = DEPTH - 1; s > 0; s--) begin
        m_v[s] <= m_v[s-1];
        m_w[s] <= m_w[s-1];
        m_l[s] <= m_l[s-1];
      end
      if (es != 0 || ef != 0 || m_mode == 1) begin
        m_v[0] <= 0;
        m_w[0] <= 0;
        m_l[0] <= 0;
      end else begin
        m_v[0] <= (bus.id_valid && bus.id_wen && bus.id_wsel != '0) ? 1 : 0;
        m_w[0] <= int'(bus.id_wsel);
        m_l[0] <= bus.id_load ? 1 : 0;
      end
      if (m_mode == 1 && ebusy == 0) m_mode <= 2;
      else if (accept) m_mode <= 1;
    end
  end

  // Compare every output against the model in the middle of each cycle.
  always @(negedge CLK) begin
    int es, ef, ea, eb, ebusy, eh;
    if (nRST === 1'b1) begin
      model_eval(es, ef, ea, eb, ebusy, eh);
      check("cmp_stall", int'(bus.stall), es);
      check("cmp_flush", int'(bus.flush), ef);
      check("cmp_fwd_a", int'(bus.fwd_a), ea);
      check("cmp_fwd_b", int'(bus.fwd_b), eb);
      check("cmp_busy",  int'(bus.busy),  ebusy);
      check("cmp_halt",  int'(bus.halt),  eh);
    end
  end

  task automatic drive(input bit valid, input int rs, input int rt,
                       input bit urs, input bit urt, input bit wen,
                       input int wsel, input bit load, input bit hlt, input bit br);
    bus.id_valid        = valid;
    bus.id_rs           = REGW'(rs);
    bus.id_rt           = REGW'(rt);
    bus.id_use_rs       = urs;
    bus.id_use_rt       = urt;
    bus.id_wen          = wen;
    bus.id_wsel         = REGW'(wsel);
    bus.id_load         = load;
    bus.id_halt         = hlt;
    bus.ex_branch_taken = br;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.advance = 1'b1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_n(input int n);
    idle();
    repeat (n) step();
  endtask

  // Present one instruction in decode and hold it until it is not stalled.
  task automatic issue(input int rs, input int rt, input bit urs, input bit urt,
                       input bit wen, input int wsel, input bit load,
                       output int n_stall, output int fa, output int fb, output int bsy);
    drive(1, rs, rt, urs, urt, wen, wsel, load, 0, 0);
    #1;
    n_stall = 0;
    while (bus.stall === 1'b1 && n_stall < 20) begin
      @(posedge CLK);
      #2;
      n_stall++;
    end
    fa  = int'(bus.fwd_a);
    fb  = int'(bus.fwd_b);
    bsy = int'(bus.busy);
    $display("issue rs=%0d rt=%0d wsel=%0d load=%0d stalls=%0d fwd_a=%0d fwd_b=%0d",
             rs, rt, wsel, load, n_stall, fa, fb);
    step();
    idle();
  endtask

  // Two writers then a HALT in decode; returns with HALT on the bus.
  task automatic drain_setup();
    int n, fa, fb, bsy;
    idle_n(4);
    issue(0, 0, 0, 0, 1, 10, 0, n, fa, fb, bsy);
    issue(0, 0, 0, 0, 1, 11, 0, n, fa, fb, bsy);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  // Count edges after HALT acceptance until halt rises; optionally hold
  // advance low on the second and third of them.
  task automatic drain_count(input bit hold, output int cnt);
    cnt = 0;
    while (bus.halt !== 1'b1 && cnt < 20) begin
      bus.advance = (hold && (cnt == 1 || cnt == 2)) ? 1'b0 : 1'b1;
      @(posedge CLK);
      #1;
      cnt++;
    end
    bus.advance = 1'b1;
  endtask

  task automatic reset_pulse();
    #2;
    nRST = 1'b0;
    @(posedge CLK);
    #3;
    nRST = 1'b1;
    step();
  endtask

  initial begin
    int n, fa, fb, bsy, cnt;
    nRST = 1'b0;
    idle();
    #3;
    check("reset_stall", int'(bus.stall), 0);
    check("reset_flush", int'(bus.flush), 0);
    check("reset_fwd_a", int'(bus.fwd_a), 0);
    check("reset_fwd_b", int'(bus.fwd_b), 0);
    check("reset_halt",  int'(bus.halt),  0);
    check("reset_busy",  int'(bus.busy),  0);
    @(posedge CLK);
    @(posedge CLK);
    #3;
    nRST = 1'b1;
    step();

    // RAW: add $3, sub reads $3, then another reader of $3.
    issue(1, 2, 0, 0, 1, 3, 0, n, fa, fb, bsy);
    issue(3, 0, 1, 0, 1, 5, 0, n, fa, fb, bsy);
`ifdef HAZARD_FWD_EN
    check("raw_sub_stalls", n, 0);
    check("raw_sub_fwd_a", fa, 1);
`else
    check("raw_sub_stalls", n, 3);
    check("raw_sub_fwd_a", fa, 0);
`endif
    issue(3, 0, 1, 0, 1, 6, 0, n, fa, fb, bsy);
    check("raw_or_stalls", n, 0);
`ifdef HAZARD_FWD_EN
    check("raw_or_fwd_a", fa, 2);
`else
    check("raw_or_fwd_a", fa, 0);
`endif

    // Load-use: lw $4 then add reading $4 via rt.
    idle_n(4);
    issue(1, 0, 1, 0, 1, 4, 1, n, fa, fb, bsy);
    issue(0, 4, 0, 1, 1, 7, 0, n, fa, fb, bsy);
`ifdef HAZARD_FWD_EN
    check("lu_stalls", n, 1);
    check("lu_fwd_b", fb, 2);
`else
    check("lu_stalls", n, 3);
    check("lu_fwd_b", fb, 0);
`endif

    // Register zero never produces a hazard.
    idle_n(4);
    issue(0, 0, 0, 0, 1, 0, 0, n, fa, fb, bsy);
    issue(0, 0, 1, 1, 1, 12, 0, n, fa, fb, bsy);
    check("r0_stalls", n, 0);
    check("r0_fwd_a", fa, 0);
    check("r0_fwd_b", fb, 0);
    check("r0_busy", bsy, 0);

    // Flush beats a load-use consumer that also carries HALT.
    idle_n(4);
    issue(0, 0, 0, 0, 1, 8, 1, n, fa, fb, bsy);
    drive(1, 0, 8, 0, 1, 1, 9, 0, 1, 1);
    #1;
    check("flush_flag", int'(bus.flush), 1);
    check("flush_stall", int'(bus.stall), 0);
    step();
    drive(1, 9, 0, 1, 0, 0, 0, 0, 0, 0);
    #1;
    check("post_flush_stall", int'(bus.stall), 0);
    check("post_flush_fwd_a", int'(bus.fwd_a), 0);
    step();
    idle();

    // Halt drain with advance held high.
    drain_setup();
    #1;
    check("halt_accept_stall", int'(bus.stall), 0);
    step();
    idle();
    drain_count(1'b0, cnt);
    check("drain_edges", cnt, 3);
    step();
    step();
    check("halted_sticky_halt", int'(bus.halt), 1);
    check("halted_sticky_stall", int'(bus.stall), 1);
    reset_pulse();

    // Halt drain with two frozen cycles in the middle.
    drain_setup();
    step();
    idle();
    drain_count(1'b1, cnt);
    check("drain_edges_held", cnt, 5);
    reset_pulse();

    // Asynchronous reset in the middle of a drain.
    drain_setup();
    step();
    idle();
    step();
    #2;
    check("drain_stall_pre_reset", int'(bus.stall), 1);
    nRST = 1'b0;
    #1;
    check("mid_reset_stall", int'(bus.stall), 0);
    check("mid_reset_busy",  int'(bus.busy),  0);
    check("mid_reset_halt",  int'(bus.halt),  0);
    @(posedge CLK);
    #3;
    nRST = 1'b1;
    step();
    issue(11, 0, 1, 0, 0, 0, 0, n, fa, fb, bsy);
    check("after_reset_stalls", n, 0);
    check("after_reset_fwd_a", fa, 0);
    check("after_reset_halt", int'(bus.halt), 0);

    idle_n(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
